// File: rtl/div_sequencer_if.sv
// div_sequencer_if
// Handshake/data bundle between the E-stage pipeline control and the
// iterative divider.
//   master : pipeline side, drives the request (start_i, signed_i, a_i, b_i,
//            flush_i, hold_i) and observes the response.
//   slave  : divider side, drives stall_o, busy_o, valid_o, hi_o, lo_o.
// Parameter WIDTH sets the operand/result width.
interface div_sequencer_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             hold_i;
  logic             stall_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, a_i, b_i, flush_i, hold_i,
    input  stall_o, busy_o, valid_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, flush_i, hold_i,
    output stall_o, busy_o, valid_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
// Multi-cycle radix-2 restoring divider with its controller for the MIPS
// execute stage. Handles DIV (signed) and DIVU (unsigned), one quotient bit
// per cycle, stalling the front of the pipeline while it iterates, then
// presents HI (remainder) and LO (quotient) with valid_o.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : div_sequencer_if.slave
//          in : start_i, signed_i, a_i, b_i, flush_i, hold_i
//          out: stall_o, busy_o, valid_o, hi_o, lo_o
// Optional feature macro: DIV_ZERO_FAST_EN
//   defined   : a zero divisor jumps straight from IDLE to DONE
//   undefined : a zero divisor runs the full WIDTH iterations
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rawA;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_qNeg;
  logic             r_rNeg;
  logic             r_divZero;
  logic             r_valid;

  logic             w_accept;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_remStep;
  logic [WIDTH-1:0] w_quoStep;
  logic             w_lastStep;
  logic [WIDTH-1:0] w_loFinal;
  logic [WIDTH-1:0] w_hiFinal;

  assign w_accept = (r_state == IDLE) && bus.start_i && !bus.flush_i;

  // Magnitudes are plain unsigned WIDTH-bit values, so the most negative
  // number negates to itself and still divides correctly.
  assign w_absA = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign w_absB = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

  // r_quo starts as the dividend; its MSB feeds the partial remainder while
  // quotient bits fill in from the bottom. The partial remainder always stays
  // below the divisor, so WIDTH bits of storage suffice.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_remStep  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quoStep  = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_lastStep = (r_cnt == CNT_W'(WIDTH - 1));

  // Zero divisor bypasses the sign fixup: LO all ones, HI the raw dividend.
  assign w_loFinal = r_divZero ? '1 :
                     (r_qNeg ? -w_quoStep : w_quoStep);
  assign w_hiFinal = r_divZero ? r_rawA :
                     (r_rNeg ? -w_remStep : w_remStep);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_rawA    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_qNeg    <= 1'b0;
      r_rNeg    <= 1'b0;
      r_divZero <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_absA;
            r_divisor <= w_absB;
            r_rawA    <= bus.a_i;
            r_qNeg    <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
            r_rNeg    <= bus.signed_i & bus.a_i[WIDTH-1];
            r_divZero <= (bus.b_i == '0);
`ifdef DIV_ZERO_FAST_EN
            if (bus.b_i == '0) begin
              r_state <= DONE;
              r_lo    <= '1;
              r_hi    <= bus.a_i;
              r_valid <= 1'b1;
            end else begin
              r_state <= BUSY;
            end
`else
            r_state <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (bus.flush_i) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_remStep;
            r_quo <= w_quoStep;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_lastStep) begin
              r_state <= DONE;
              r_lo    <= w_loFinal;
              r_hi    <= w_hiFinal;
              r_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // start_i here is the same instruction leaving E, so it is ignored.
          if (bus.flush_i || !bus.hold_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so the hazard unit stalls in the accept cycle itself.
  assign bus.stall_o = ((r_state == IDLE) && bus.start_i && !bus.flush_i) ||
                       (r_state == BUSY);
  assign bus.busy_o  = (r_state != IDLE);
  assign bus.valid_o = r_valid;
  assign bus.hi_o    = r_hi;
  assign bus.lo_o    = r_lo;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Scoreboard bench for div_sequencer: directed divides push their expected
// HI/LO into a queue, and an independent monitor pops and compares on every
// rising edge of valid_o. Timing (stall/valid latency, hold, flush, reset)
// is checked directly by the stimulus process.
module tb_div_sequencer;
  localparam int WIDTH    = 32;
  localparam int FULL_LAT = WIDTH + 1;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = WIDTH + 1;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  result_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  div_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleCycle();
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one divide from the current negedge and follows it to its last
  // valid cycle; returns at the negedge of that cycle with start_i still high.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input int holdCycles,
                               input int expLat, input int expWait,
                               input logic [31:0] expHi, input logic [31:0] expLo);
    int waited;
    int n;
    logic got;
    logic stallBad;
    result_t e;
    e.hi = expHi;
    e.lo = expLo;
    expQ.push_back(e);
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.hold_i   = 1'b0;
    bus.flush_i  = 1'b0;
    waited = 0;
    while (bus.busy_o && waited < 5) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    #1;
    checkOutput("acceptWait", waited, expWait);
    checkOutput("stallAccept", {31'b0, bus.stall_o}, 1);
    n = 0;
    got = 1'b0;
    stallBad = 1'b0;
    while (n < WIDTH + 8 && !got) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.valid_o) got = 1'b1;
      else if (!bus.stall_o) stallBad = 1'b1;
    end
    checkOutput("latency", n, expLat);
    checkOutput("stallWhileBusy", {31'b0, stallBad}, 0);
    checkOutput("stallInDone", {31'b0, bus.stall_o}, 0);
    if (holdCycles > 0) begin
      bus.hold_i = 1'b1;
      for (int i = 0; i < holdCycles; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("holdValid", {31'b0, bus.valid_o}, 1);
        checkOutput("holdStall", {31'b0, bus.stall_o}, 0);
        checkOutput("holdLo", bus.lo_o, expLo);
        checkOutput("holdHi", bus.hi_o, expHi);
      end
      bus.hold_i = 1'b0;
    end
  endtask

  // Monitor: compares each new result against the scoreboard head.
  initial begin
    logic prevValid;
    result_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid = 1'b0;
      end else begin
        if (bus.valid_o && !prevValid) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedValid: got valid with lo=0x%08h hi=0x%08h, expected none",
                     bus.lo_o, bus.hi_o);
          end else begin
            e = expQ.pop_front();
            checkOutput("lo", bus.lo_o, e.lo);
            checkOutput("hi", bus.hi_o, e.hi);
          end
        end
        prevValid = bus.valid_o;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seenValid;
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.flush_i  = 1'b0;
    bus.hold_i   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstValid", {31'b0, bus.valid_o}, 0);
    checkOutput("rstBusy", {31'b0, bus.busy_o}, 0);
    checkOutput("rstStall", {31'b0, bus.stall_o}, 0);
    checkOutput("rstHi", bus.hi_o, 0);
    checkOutput("rstLo", bus.lo_o, 0);
    @(negedge clk);

    $display("[TB] unsigned and signed divides");
    applyStimulus(1'b0, 32'd100, 32'd7, 0, FULL_LAT, 0, 32'd2, 32'd14);
    idleCycle();
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 0, FULL_LAT, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    idleCycle();
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 0, FULL_LAT, 0, 32'd1, 32'hFFFFFFFD);
    idleCycle();
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, FULL_LAT, 0, 32'h0, 32'h80000000);
    idleCycle();

    $display("[TB] zero divisor");
    applyStimulus(1'b0, 32'd5, 32'd0, 0, ZERO_LAT, 0, 32'd5, 32'hFFFFFFFF);
    idleCycle();
    applyStimulus(1'b1, 32'hFFFFFFF8, 32'd0, 0, ZERO_LAT, 0, 32'hFFFFFFF8, 32'hFFFFFFFF);
    idleCycle();

    $display("[TB] hold in DONE with start_i held");
    applyStimulus(1'b0, 32'd1000, 32'd10, 3, FULL_LAT, 0, 32'd0, 32'd100);
    idleCycle();
    checkOutput("afterHoldBusy", {31'b0, bus.busy_o}, 0);
    checkOutput("afterHoldValid", {31'b0, bus.valid_o}, 0);

    $display("[TB] back-to-back divides");
    applyStimulus(1'b0, 32'd100, 32'd7, 0, FULL_LAT, 0, 32'd2, 32'd14);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'h10, 0, FULL_LAT, 1, 32'hF, 32'h0FFFFFFF);
    idleCycle();

    $display("[TB] flush mid-divide");
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'd1000;
    bus.b_i      = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("preFlushBusy", {31'b0, bus.busy_o}, 1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("flushBusy", {31'b0, bus.busy_o}, 0);
    checkOutput("flushStall", {31'b0, bus.stall_o}, 0);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    seenValid = 1'b0;
    for (int i = 0; i < WIDTH + 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.valid_o) seenValid = 1'b1;
    end
    checkOutput("flushNoValid", {31'b0, seenValid}, 0);
    checkOutput("flushHi", bus.hi_o, 32'hF);
    checkOutput("flushLo", bus.lo_o, 32'h0FFFFFFF);

    $display("[TB] async reset mid-divide");
    bus.start_i = 1'b1;
    bus.a_i     = 32'd50;
    bus.b_i     = 32'd3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midRstHi", bus.hi_o, 0);
    checkOutput("midRstLo", bus.lo_o, 0);
    checkOutput("midRstValid", {31'b0, bus.valid_o}, 0);
    checkOutput("midRstBusy", {31'b0, bus.busy_o}, 0);
    checkOutput("midRstStall", {31'b0, bus.stall_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 32'd100, 32'd7, 0, FULL_LAT, 0, 32'd2, 32'd14);
    idleCycle();
    repeat (3) idleCycle();
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
